// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RISC-V memory stage: ALU pass-through, byte-serial load/store FSM over an 8-bit RAM port.
// Optional alignment trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage #(
  parameter int RAM_ADDR_W = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            ex_waddr,
  input  logic                  ex_we,
  input  logic [31:0]           ex_wdata,
  input  logic                  ex_ld,
  input  logic                  ex_st,
  input  logic [2:0]            ex_funct3,
  input  logic [31:0]           ex_maddr,
  input  logic [31:0]           ex_sdata,
  output logic [4:0]            mem_waddr,
  output logic                  mem_we,
  output logic [31:0]           mem_wdata,
  output logic                  stallreq,
  output logic                  ram_req,
  output logic                  ram_rw,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [7:0]            ram_wdata,
  input  logic [7:0]            ram_rdata,
  input  logic                  ram_ack,
  output logic                  excp_misalign
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [31:0]           buf_q, buf_d;
  logic                  ram_req_q, ram_req_d;
  logic                  ram_rw_q, ram_rw_d;
  logic [RAM_ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]            ram_wdata_q, ram_wdata_d;

  logic                  is_mem;
  logic                  is_store;
  logic                  misalign;
  logic [1:0]            last_idx;
  logic [1:0]            idx_nxt;
  logic [31:0]           ld_ext;
  logic                  unused_maddr_hi;

  assign is_mem          = ex_ld | ex_st;
  assign is_store        = ex_st;
  assign idx_nxt         = idx_q + 2'd1;
  assign last_idx        = ex_funct3[1] ? 2'd3 : {1'b0, ex_funct3[0]};
  assign unused_maddr_hi = ^ex_maddr[31:RAM_ADDR_W];

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = is_mem & ((ex_funct3[1:0] == 2'b01 & ex_maddr[0]) |
                              (ex_funct3[1] & (ex_maddr[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    ld_ext = buf_q;
    case (ex_funct3)
      3'b000:  ld_ext = {{24{buf_q[7]}}, buf_q[7:0]};
      3'b100:  ld_ext = {24'd0, buf_q[7:0]};
      3'b001:  ld_ext = {{16{buf_q[15]}}, buf_q[15:0]};
      3'b101:  ld_ext = {16'd0, buf_q[15:0]};
      default: ld_ext = buf_q;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    buf_d         = buf_q;
    ram_req_d     = ram_req_q;
    ram_rw_d      = ram_rw_q;
    ram_addr_d    = ram_addr_q;
    ram_wdata_d   = ram_wdata_q;
    mem_waddr     = 5'd0;
    mem_we        = 1'b0;
    mem_wdata     = 32'd0;
    stallreq      = 1'b0;
    excp_misalign = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          mem_waddr = ex_waddr;
          if (misalign) begin
            excp_misalign = 1'b1;
          end else if (is_mem) begin
            stallreq    = 1'b1;
            state_d     = ACCESS;
            idx_d       = 2'd0;
            ram_req_d   = 1'b1;
            ram_rw_d    = is_store;
            ram_addr_d  = ex_maddr[RAM_ADDR_W-1:0];
            ram_wdata_d = ex_sdata[7:0];
          end else begin
            mem_we    = ex_we;
            mem_wdata = ex_wdata;
          end
        end
        ACCESS: begin
          stallreq  = 1'b1;
          mem_waddr = ex_waddr;
          // ex_* stay frozen while stalled, so the next byte is derived from them directly
          if (ram_ack) begin
            buf_d[{idx_q, 3'b000} +: 8] = ram_rdata;
            if (idx_q != last_idx) begin
              idx_d       = idx_nxt;
              ram_addr_d  = ex_maddr[RAM_ADDR_W-1:0] + {{(RAM_ADDR_W-2){1'b0}}, idx_nxt};
              ram_wdata_d = ex_sdata[{idx_nxt, 3'b000} +: 8];
            end else begin
              idx_d     = 2'd0;
              ram_req_d = 1'b0;
              state_d   = DONE;
            end
          end
        end
        DONE: begin
          mem_waddr = ex_waddr;
          if (!is_store) begin
            mem_we    = ex_we;
            mem_wdata = ld_ext;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= 2'd0;
      buf_q       <= 32'd0;
      ram_req_q   <= 1'b0;
      ram_rw_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      buf_q       <= buf_d;
      ram_req_q   <= ram_req_d;
      ram_rw_q    <= ram_rw_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  // RAM port is forced quiet for the whole reset window, not just after the edge
  assign ram_req   = ram_req_q & ~rst;
  assign ram_rw    = ram_rw_q & ~rst;
  assign ram_addr  = rst ? '0 : ram_addr_q;
  assign ram_wdata = rst ? 8'd0 : ram_wdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized self-checking bench for mem_stage against a behavioural RAM/load model.
module tb_mem_stage;
  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    ex_waddr;
  logic          ex_we;
  logic [31:0]   ex_wdata;
  logic          ex_ld;
  logic          ex_st;
  logic [2:0]    ex_funct3;
  logic [31:0]   ex_maddr;
  logic [31:0]   ex_sdata;
  logic [4:0]    mem_waddr;
  logic          mem_we;
  logic [31:0]   mem_wdata;
  logic          stallreq;
  logic          ram_req;
  logic          ram_rw;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_rdata;
  logic          ram_ack;
  logic          excp_misalign;

  always #5 clk = ~clk;

  mem_stage #(.RAM_ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .ex_waddr(ex_waddr), .ex_we(ex_we), .ex_wdata(ex_wdata),
    .ex_ld(ex_ld), .ex_st(ex_st), .ex_funct3(ex_funct3),
    .ex_maddr(ex_maddr), .ex_sdata(ex_sdata),
    .mem_waddr(mem_waddr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .stallreq(stallreq),
    .ram_req(ram_req), .ram_rw(ram_rw), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ack(ram_ack),
    .excp_misalign(excp_misalign)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  logic [7:0]  mem [0:(1<<AW)-1];
  logic [24:0] wr_log[$];
  int          wait_cfg = 0;
  int          wait_sel = -1;

  // RAM responder: stalls wait_cfg cycles on selected bytes, checks the port holds while stalled
  initial begin
    int            wcnt;
    int            bidx;
    int            need;
    logic          waiting;
    logic [AW-1:0] h_addr;
    logic          h_rw;
    logic [7:0]    h_wd;
    wcnt = 0; bidx = 0; waiting = 1'b0;
    h_addr = '0; h_rw = 1'b0; h_wd = 8'd0;
    ram_ack = 1'b0;
    ram_rdata = 8'd0;
    forever begin
      @(negedge clk);
      if (ram_req) begin
        need = (wait_sel < 0 || wait_sel == bidx) ? wait_cfg : 0;
        if (waiting) begin
          check("ram_addr_hold", ram_addr, h_addr);
          check("ram_rw_hold", ram_rw, h_rw);
          check("ram_wdata_hold", ram_wdata, h_wd);
        end
        if (wcnt >= need) begin
          ram_ack   = 1'b1;
          ram_rdata = mem[ram_addr];
          if (ram_rw) begin
            mem[ram_addr] = ram_wdata;
            wr_log.push_back({ram_addr, ram_wdata});
          end
          wcnt = 0; bidx++; waiting = 1'b0;
        end else begin
          ram_ack   = 1'b0;
          ram_rdata = 8'($urandom);
          wcnt++; waiting = 1'b1;
          h_addr = ram_addr; h_rw = ram_rw; h_wd = ram_wdata;
        end
      end else begin
        ram_ack = 1'b0; wcnt = 0; bidx = 0; waiting = 1'b0;
      end
    end
  end

  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1]) return 4;
    return f3[0] ? 2 : 1;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
    int            n;
    longint        v;
    logic [AW-1:0] a;
    n = nbytes(f3);
    v = 0;
    for (int i = 0; i < n; i++) begin
      a = addr[AW-1:0] + AW'(i);
      v += longint'(mem[a]) << (8 * i);
    end
    if (f3 == 3'b000 && v >= 128)   v -= 256;
    if (f3 == 3'b001 && v >= 32768) v -= 65536;
    return v[31:0];
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [31:0] addr);
    if (nbytes(f3) == 2) return (addr % 2) != 0;
    if (nbytes(f3) == 4) return (addr % 4) != 0;
    return 1'b0;
  endfunction

  task automatic drive_idle();
    ex_ld = 1'b0; ex_st = 1'b0;
    ex_waddr = 5'($urandom); ex_we = 1'($urandom); ex_wdata = $urandom;
    ex_funct3 = 3'($urandom); ex_maddr = $urandom; ex_sdata = $urandom;
  endtask

  task automatic alu_op(input logic [4:0] wa, input logic [31:0] wd, input logic we);
    @(posedge clk); #1;
    ex_ld = 1'b0; ex_st = 1'b0; ex_waddr = wa; ex_wdata = wd; ex_we = we;
    ex_maddr = $urandom; ex_sdata = $urandom; ex_funct3 = 3'($urandom);
    @(negedge clk);
    check("alu_waddr", mem_waddr, wa);
    check("alu_we", mem_we, we);
    check("alu_wdata", mem_wdata, wd);
    check("alu_stall", stallreq, 0);
    check("alu_ram_req", ram_req, 0);
    check("alu_excp", excp_misalign, 0);
  endtask

  task automatic run_mem(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [4:0] wa, input logic we,
                         input int wt, input int wsel, input string tag,
                         output logic [31:0] got);
    int            n;
    int            cnt;
    int            exp_stall;
    logic [31:0]   exp_load;
    logic [AW-1:0] a;
    n = nbytes(f3);
    wait_cfg = wt;
    wait_sel = wsel;
    exp_load = model_load(f3, addr);
    wr_log.delete();
    @(posedge clk); #1;
    ex_ld = ld; ex_st = st; ex_funct3 = f3; ex_maddr = addr; ex_sdata = sdata;
    ex_waddr = wa; ex_we = we; ex_wdata = $urandom;
`ifdef MEM_ALIGN_CHECK_EN
    if (misaligned(f3, addr)) begin
      @(negedge clk);
      got = mem_wdata;
      check({tag, "_excp"}, excp_misalign, 1);
      check({tag, "_excp_stall"}, stallreq, 0);
      check({tag, "_excp_we"}, mem_we, 0);
      check({tag, "_excp_wdata"}, mem_wdata, 0);
      check({tag, "_excp_req"}, ram_req, 0);
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      check({tag, "_excp_req_after"}, ram_req, 0);
      check({tag, "_excp_clear"}, excp_misalign, 0);
      return;
    end
`endif
    exp_stall = n + 1 + ((wsel < 0) ? n * wt : ((wsel < n) ? wt : 0));
    cnt = 0;
    @(negedge clk);
    while (stallreq && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    got = mem_wdata;
    check({tag, "_stall_cycles"}, cnt, exp_stall);
    check({tag, "_waddr"}, mem_waddr, wa);
    check({tag, "_we"}, mem_we, st ? 1'b0 : we);
    check({tag, "_wdata"}, mem_wdata, st ? 32'd0 : exp_load);
    check({tag, "_excp"}, excp_misalign, 0);
    if (st) begin
      check({tag, "_nwrites"}, wr_log.size(), n);
      for (int i = 0; i < n && i < wr_log.size(); i++) begin
        a = addr[AW-1:0] + AW'(i);
        check({tag, "_wr_byte"}, wr_log[i], {a, 8'((sdata >> (8 * i)) & 32'hFF)});
      end
    end
    @(posedge clk); #1;
    drive_idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] got;
    logic [2:0]  f3;
    logic        found;
    int          kind;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);

    rst = 1'b1;
    ex_ld = 1'b1; ex_st = 1'b0; ex_we = 1'b1; ex_waddr = 5'd9;
    ex_wdata = 32'hDEADBEEF; ex_funct3 = 3'b010; ex_maddr = 32'h40; ex_sdata = 32'h55;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_waddr", mem_waddr, 0);
    check("rst_we", mem_we, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_stall", stallreq, 0);
    check("rst_ram_req", ram_req, 0);
    check("rst_ram_rw", ram_rw, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_excp", excp_misalign, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive_idle();

    alu_op(5'd5, 32'h1234, 1'b1);

    run_mem(1'b0, 1'b1, 3'b010, 32'h100, 32'hA1B2C3D4, 5'd3, 1'b1, 0, -1, "sw", got);
    check("sw_mem_100", mem[17'h100], 8'hD4);
    check("sw_mem_103", mem[17'h103], 8'hA1);

    mem[17'h101] = 8'h80;
    run_mem(1'b1, 1'b0, 3'b000, 32'h101, $urandom, 5'd7, 1'b1, 1, -1, "lb", got);
    check("lb_value", got, 32'hFFFFFF80);
    run_mem(1'b1, 1'b0, 3'b100, 32'h101, $urandom, 5'd7, 1'b1, 1, -1, "lbu", got);
    check("lbu_value", got, 32'h00000080);

    mem[17'h200] = 8'h34;
    mem[17'h201] = 8'h85;
    run_mem(1'b1, 1'b0, 3'b001, 32'h200, $urandom, 5'd8, 1'b1, 3, 1, "lh", got);
    check("lh_value", got, 32'hFFFF8534);
    run_mem(1'b1, 1'b0, 3'b101, 32'h200, $urandom, 5'd8, 1'b1, 0, -1, "lhu", got);
    check("lhu_value", got, 32'h00008534);

    run_mem(1'b1, 1'b0, 3'b010, 32'h200, $urandom, 5'd0, 1'b1, 0, -1, "lw_x0", got);

    // reset while byte 2 of an LW is pending
    wait_cfg = 1; wait_sel = -1;
    @(posedge clk); #1;
    ex_ld = 1'b1; ex_st = 1'b0; ex_funct3 = 3'b010; ex_maddr = 32'h300;
    ex_waddr = 5'd4; ex_we = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      if (ram_req && ram_addr == 17'h302) found = 1'b1;
    end
    check("rst_mid_reached_byte2", found, 1);
    rst = 1'b1;
    ex_ld = 1'b0;
    #1;
    check("rst_mid_comb_req", ram_req, 0);
    check("rst_mid_comb_stall", stallreq, 0);
    @(posedge clk); #1;
    check("rst_mid_req", ram_req, 0);
    check("rst_mid_stall", stallreq, 0);
    check("rst_mid_we", mem_we, 0);
    check("rst_mid_wdata", mem_wdata, 0);
    check("rst_mid_addr", ram_addr, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive_idle();
    @(negedge clk);
    check("rst_rel_req", ram_req, 0);
    check("rst_rel_stall", stallreq, 0);
    mem[17'h3A0] = 8'hF1;
    run_mem(1'b1, 1'b0, 3'b000, 32'h3A0, $urandom, 5'd6, 1'b1, 0, -1, "lb_after_rst", got);
    check("lb_after_rst_value", got, 32'hFFFFFFF1);

    mem[17'h102] = 8'h11; mem[17'h103] = 8'h22; mem[17'h104] = 8'h33; mem[17'h105] = 8'h44;
    run_mem(1'b1, 1'b0, 3'b010, 32'h102, $urandom, 5'd10, 1'b1, 0, -1, "lw_mis", got);
`ifdef MEM_ALIGN_CHECK_EN
    check("lw_mis_value", got, 32'h0);
`else
    check("lw_mis_value", got, 32'h44332211);
`endif

    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 9);
      case ($urandom_range(0, 4))
        0: f3 = 3'b000;
        1: f3 = 3'b100;
        2: f3 = 3'b001;
        3: f3 = 3'b101;
        default: f3 = 3'b010;
      endcase
      if (kind < 2) begin
        alu_op(5'($urandom), $urandom, 1'($urandom));
      end else begin
        if (kind >= 7) f3 = {1'b0, f3[1:0]};
        run_mem(kind < 7, kind >= 6, f3, $urandom, $urandom, 5'($urandom), 1'($urandom),
                $urandom_range(0, 2), ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, 3),
                "rnd", got);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
